// File: rtl/rgb_ycbcr_conv.sv
// ---------------------------------------------------------------------------
// rgb_ycbcr_conv
//   Converts demosaiced RGB pixels to 8-bit YCbCr (BT.601-style integer
//   coefficients) in a fixed 3-stage pipeline. It accepts one pixel per cycle
//   and never stalls. Pixel coordinates and the valid flag travel beside the
//   data. The block also flags the top-left pixel of each compression block
//   and counts valid pixels per frame.
//
//   Configuration macro: YCBCR_CHROMA_EN
//     defined   : Cb/Cr datapath is built.
//     undefined : only luma is computed. oCb/oCr are tied to 128.
//
// Parameters
//   BLK_LOG2   log2 of the compression block edge (3 -> 8x8 blocks)
//   CNT_W      width of the per-frame valid-pixel counter
//
// Ports
//   VGA_CLK            in   sole clock, rising edge
//   RESET_N            in   asynchronous active-low reset
//   iRed/iGreen/iBlue  in   8-bit RGB pixel
//   iX_Cont/iY_Cont    in   11-bit column/row of the pixel
//   iVALID             in   input pixel valid
//   VGA_VS             in   vertical sync, active high
//   oLuma/oCb/oCr      out  8-bit YCbCr result (don't-care while !oVALID)
//   oX_Cont/oY_Cont    out  coordinates aligned with the result
//   oVALID             out  result valid
//   oBLK_START         out  result is the top-left pixel of a block
//   oFRAME_PIX         out  valid-pixel count of the last completed frame
// ---------------------------------------------------------------------------
module rgb_ycbcr_conv #(
  parameter int BLK_LOG2 = 3,
  parameter int CNT_W    = 20
) (
  input  logic             VGA_CLK,
  input  logic             RESET_N,
  input  logic [7:0]       iRed,
  input  logic [7:0]       iGreen,
  input  logic [7:0]       iBlue,
  input  logic [10:0]      iX_Cont,
  input  logic [10:0]      iY_Cont,
  input  logic             iVALID,
  input  logic             VGA_VS,
  output logic [7:0]       oLuma,
  output logic [7:0]       oCb,
  output logic [7:0]       oCr,
  output logic [10:0]      oX_Cont,
  output logic [10:0]      oY_Cont,
  output logic             oVALID,
  output logic             oBLK_START,
  output logic [CNT_W-1:0] oFRAME_PIX
);

  // Clamp a signed value to 0..255.
  function automatic logic [7:0] sat_u8(input logic signed [17:0] v);
    if (v < 18'sd0)        return 8'd0;
    else if (v > 18'sd255) return 8'd255;
    else                   return v[7:0];
  endfunction

  // -------------------------------------------------------------------------
  // Side-band pipeline: valid and coordinates, 3 deep
  // -------------------------------------------------------------------------
  logic [2:0]  vld_q;
  logic [10:0] x_q [3];
  logic [10:0] y_q [3];

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vld_q <= '0;
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      vld_q <= {vld_q[1:0], iVALID};
      x_q[0] <= iX_Cont;
      y_q[0] <= iY_Cont;
      for (int i = 1; i < 3; i++) begin
        x_q[i] <= x_q[i-1];
        y_q[i] <= y_q[i-1];
      end
    end
  end

  assign oVALID  = vld_q[2];
  assign oX_Cont = x_q[2];
  assign oY_Cont = y_q[2];
  assign oBLK_START = vld_q[2]
                    && (x_q[2][BLK_LOG2-1:0] == '0)
                    && (y_q[2][BLK_LOG2-1:0] == '0);

  // -------------------------------------------------------------------------
  // Luma datapath. Products are unsigned magnitudes, and signs are applied
  // in the sum stage. 18 signed bits cover the full range: 255*256+128.
  // -------------------------------------------------------------------------
  logic [15:0]        p_yr_q, p_yg_q, p_yb_q;
  logic signed [17:0] sum_y_q;
  logic [7:0]         luma_q;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      p_yr_q  <= '0;
      p_yg_q  <= '0;
      p_yb_q  <= '0;
      sum_y_q <= '0;
      luma_q  <= '0;
    end else begin
      p_yr_q  <= 16'(iRed)   * 16'd77;
      p_yg_q  <= 16'(iGreen) * 16'd150;
      p_yb_q  <= 16'(iBlue)  * 16'd29;
      sum_y_q <= $signed({2'b00, p_yr_q}) + $signed({2'b00, p_yg_q})
               + $signed({2'b00, p_yb_q}) + 18'sd128;
      luma_q  <= sat_u8(sum_y_q >>> 8);
    end
  end

  assign oLuma = luma_q;

`ifdef YCBCR_CHROMA_EN
  // -------------------------------------------------------------------------
  // Chroma datapath. Each coefficient row sums to zero, so each sum stays
  // within roughly +/-32768 before the +128 offset.
  // -------------------------------------------------------------------------
  logic [15:0]        p_cbr_q, p_cbg_q, p_cbb_q;
  logic [15:0]        p_crr_q, p_crg_q, p_crb_q;
  logic signed [17:0] sum_cb_q, sum_cr_q;
  logic [7:0]         cb_q, cr_q;

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      p_cbr_q  <= '0;
      p_cbg_q  <= '0;
      p_cbb_q  <= '0;
      p_crr_q  <= '0;
      p_crg_q  <= '0;
      p_crb_q  <= '0;
      sum_cb_q <= '0;
      sum_cr_q <= '0;
      cb_q     <= '0;
      cr_q     <= '0;
    end else begin
      p_cbr_q  <= 16'(iRed)   * 16'd43;
      p_cbg_q  <= 16'(iGreen) * 16'd85;
      p_cbb_q  <= 16'(iBlue)  * 16'd128;
      p_crr_q  <= 16'(iRed)   * 16'd128;
      p_crg_q  <= 16'(iGreen) * 16'd107;
      p_crb_q  <= 16'(iBlue)  * 16'd21;
      sum_cb_q <= $signed({2'b00, p_cbb_q}) - $signed({2'b00, p_cbr_q})
                - $signed({2'b00, p_cbg_q}) + 18'sd128;
      sum_cr_q <= $signed({2'b00, p_crr_q}) - $signed({2'b00, p_crg_q})
                - $signed({2'b00, p_crb_q}) + 18'sd128;
      cb_q     <= sat_u8((sum_cb_q >>> 8) + 18'sd128);
      cr_q     <= sat_u8((sum_cr_q >>> 8) + 18'sd128);
    end
  end

  assign oCb = cb_q;
  assign oCr = cr_q;
`else
  assign oCb = 8'd128;
  assign oCr = 8'd128;
`endif

  // -------------------------------------------------------------------------
  // Per-frame valid-pixel counter
  // -------------------------------------------------------------------------
  // armed_q masks the first cycle after reset. Otherwise a VGA_VS that is
  // already high would look like a rising edge against the cleared vs_q.
  logic             vs_q, armed_q, vs_rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] frame_q, frame_d;

  assign vs_rise = armed_q && VGA_VS && !vs_q;

  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (vs_rise) begin
      frame_d = cnt_q;
      cnt_d   = iVALID ? CNT_W'(1) : '0;
    end else if (iVALID && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge VGA_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_q    <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      vs_q    <= VGA_VS;
      armed_q <= 1'b1;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign oFRAME_PIX = frame_q;

endmodule

// File: doc/rgb_ycbcr_conv.md
RGB_YCBCR_CONV -- requirements
Module: rgb_ycbcr_conv

Interface
REQ-001 Parameter BLK_LOG2, default 3, log2 of the compression block edge (8x8 blocks for the DCT stage).
REQ-002 Parameter CNT_W, default 20, width of the per-frame valid-pixel counter.
REQ-003 VGA_CLK  in  1  sole clock; all state on its rising edge.
REQ-004 RESET_N  in  1  asynchronous, active-low reset.
REQ-005 iRed / iGreen / iBlue  in  8 each  demosaiced RGB pixel from the Bayer-to-RGB stage.
REQ-006 iX_Cont / iY_Cont  in  11 each  pixel column and row, aligned with the RGB data.
REQ-007 iVALID  in  1  RGB and coordinates are valid this cycle.
REQ-008 VGA_VS  in  1  vertical sync, active high at frame boundary.
REQ-009 oLuma / oCb / oCr  out  8 each  YCbCr result.
REQ-010 oX_Cont / oY_Cont  out  11 each  coordinates delayed to match the result.
REQ-011 oVALID  out  1  result valid.
REQ-012 oBLK_START  out  1  result is the top-left pixel of a block.
REQ-013 oFRAME_PIX  out  CNT_W  valid-pixel count of the last completed frame.

Function
REQ-014 Pipeline SHALL be exactly 3 stages: latency 3 cycles from iVALID to oVALID, no stalls, one pixel per cycle.
REQ-015 Stage 1 SHALL register the unsigned 8x8 products of each input with the coefficients: Y 77/150/29; Cb -43/-85/128; Cr 128/-107/-21.
REQ-016 Stage 2 SHALL register signed sums of at least 18 bits, each plus a rounding constant of 128.
REQ-017 Stage 3 SHALL arithmetic-shift each sum right by 8, add 128 to Cb and Cr, and saturate to 0..255.
REQ-018 No internal overflow before saturation at any input combination.
REQ-019 iVALID, iX_Cont and iY_Cont SHALL travel in a 3-deep shift register beside the data.
REQ-020 Data stages SHALL load every cycle regardless of iVALID.
REQ-021 While oVALID=0, oLuma/oCb/oCr are don't-care.
REQ-022 oBLK_START SHALL equal oVALID AND low BLK_LOG2 bits of oX_Cont zero AND low BLK_LOG2 bits of oY_Cont zero.
REQ-023 Valid-pixel counter SHALL increment on each cycle with iVALID=1.
REQ-024 Counter SHALL saturate at 2^CNT_W-1 rather than wrap.
REQ-025 VGA_VS rising edge SHALL be detected from a registered copy of VGA_VS.
REQ-026 On that edge cycle, oFRAME_PIX SHALL load the counter value.
REQ-027 On that edge cycle, the counter SHALL restart at 1 if iVALID=1, else 0.
REQ-028 oFRAME_PIX SHALL hold between edges.

Reset
REQ-029 RESET_N low SHALL immediately clear all valid-pipeline bits, coordinates, the counter, oFRAME_PIX, the VS history bit, oLuma, oCb and oCr.
REQ-030 oVALID and oBLK_START SHALL be 0 during reset.
REQ-031 Reset asserted mid-frame SHALL discard in-flight pixels; no stale oVALID after release.
REQ-032 First oVALID SHALL appear no earlier than 3 cycles after the first post-release iVALID.
REQ-033 A VGA_VS already high at reset release SHALL NOT count as a rising edge.

Configuration
REQ-034 Macro YCBCR_CHROMA_EN defined: Cb/Cr datapath built as specified.
REQ-035 YCBCR_CHROMA_EN undefined: Cb/Cr multipliers and adders are not instantiated, and oCb and oCr are constant 128 (also in reset).
REQ-036 Luma, timing, oBLK_START and the counter SHALL be identical with or without YCBCR_CHROMA_EN.

Verification
REQ-037 RGB=(255,255,255) valid -> 3 cycles later Y=255, Cb=128, Cr=128, oVALID=1.
REQ-038 RGB=(255,0,0) -> Y=77, Cb=85, Cr=255 (saturated); RGB=(0,0,255) -> Y=29, Cb=255, Cr=107; RGB=(0,0,0) -> Y=0, Cb=Cr=128.
REQ-039 Raster with x 0..15, y 0..8 -> oBLK_START high only at (0,0), (8,0), (0,8), (8,8), coordinates matching the data.
REQ-040 Frame of 640x480 valid pixels between two VGA_VS rises -> oFRAME_PIX=307200 after the second rise.
REQ-041 RESET_N pulsed low with 2 pixels in flight -> oVALID stays 0 until 3 cycles after the next iVALID.
REQ-042 Build without YCBCR_CHROMA_EN, RGB=(255,0,0) -> Y=77, Cb=128, Cr=128.
